// File: rtl/cyborg65r3_pkg.sv
// Shared definitions for the cyborg65r3 SRAM access controller.
package cyborg65r3_pkg;

    // Default geometry of the coefficient SRAM.
    localparam int unsigned NUM_BANKS_DEF = 4;
    localparam int unsigned ADDR_W_DEF    = 12;
    localparam int unsigned DATA_W_DEF    = 16;

    // Access FSM state encoding.
    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StWrReq  = 3'd1;
    localparam state_t StRdReq  = 3'd2;
    localparam state_t StRdWait = 3'd3;
    localparam state_t StDone   = 3'd4;

endpackage

// File: rtl/cyborg65r3_addr_ptr.sv
// Word-address pointer: loadable, with modulo-2^ADDR_W post-increment.
module cyborg65r3_addr_ptr
    import cyborg65r3_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_8rs,
    input  logic              resetb,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] value,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Load has priority; increment wraps naturally at all-ones.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = value;
        end else if (inc) begin
            ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Pointer register.
    always_ff @(posedge clk_8rs or negedge resetb) begin
        if (!resetb) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/cyborg65r3_sram_access_ctrl.sv
// Config-side SRAM access controller: single read/write accesses to the
// coefficient banks through the DSP/config arbiter.
module cyborg65r3_sram_access_ctrl
    import cyborg65r3_pkg::*;
#(
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic                 clk_8rs,
    input  logic                 resetb,
    input  logic [NUM_BANKS-1:0] cfg_bank_en,
    input  logic                 cfg_auto_inc,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic                 cfg_addr_load,
    input  logic [DATA_W-1:0]    cfg_wdata,
    input  logic                 start_wr,
    input  logic                 start_rd,
    input  logic                 err_clr,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [NUM_BANKS-1:0] mem_bank_en,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_gnt,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_done,
    output logic                 wr_done,
    output logic                 busy,
    output logic [ADDR_W-1:0]    addr_ptr,
    output logic                 err_overrun,
    output logic                 err_nobank
);

    state_t                state_q, state_d;
    logic [NUM_BANKS-1:0]  bank_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  rd_done_q, wr_done_q;
    logic                  err_overrun_q, err_overrun_d;
    logic                  err_nobank_q, err_nobank_d;

    logic is_idle, start_any, bank_ok, accept, in_req;
    logic overrun_set, nobank_set;
    logic ptr_load, ptr_inc;

    assign is_idle   = (state_q == StIdle);
    assign start_any = start_wr | start_rd;
    assign bank_ok   = |cfg_bank_en;
    assign accept    = is_idle & start_any & bank_ok;
    assign in_req    = (state_q == StWrReq) | (state_q == StRdReq);

    // Simultaneous starts in IDLE drop the read; any start while busy is lost.
    assign overrun_set = (is_idle & start_wr & start_rd) | (~is_idle & start_any);
    assign nobank_set  = is_idle & start_any & ~bank_ok;

    // Loads while busy are silently dropped so the access address stays stable.
    assign ptr_load = is_idle & cfg_addr_load;
    assign ptr_inc  = (state_q == StDone) & cfg_auto_inc;

    // Next-state logic for the access FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = start_wr ? StWrReq : StRdReq;
            StWrReq:  if (mem_gnt) state_d = StDone;
            StRdReq:  if (mem_gnt) state_d = StRdWait;
            StRdWait: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Sticky error flags; a new error event beats a coincident clear.
    always_comb begin
        err_overrun_d = err_overrun_q;
        err_nobank_d  = err_nobank_q;
        if (err_clr) begin
            err_overrun_d = 1'b0;
            err_nobank_d  = 1'b0;
        end
        if (overrun_set) err_overrun_d = 1'b1;
        if (nobank_set)  err_nobank_d  = 1'b1;
    end

    // FSM, latched access attributes, read capture and completion pulses.
    always_ff @(posedge clk_8rs or negedge resetb) begin
        if (!resetb) begin
            state_q       <= StIdle;
            bank_q        <= '0;
            wdata_q       <= '0;
            rd_data_q     <= '0;
            rd_done_q     <= 1'b0;
            wr_done_q     <= 1'b0;
            err_overrun_q <= 1'b0;
            err_nobank_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_overrun_q <= err_overrun_d;
            err_nobank_q  <= err_nobank_d;
            wr_done_q     <= (state_q == StWrReq) & mem_gnt;
            rd_done_q     <= (state_q == StRdWait);
            if (accept) begin
                bank_q  <= cfg_bank_en;
                wdata_q <= cfg_wdata;
            end
            if (state_q == StRdWait) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    cyborg65r3_addr_ptr #(
        .ADDR_W (ADDR_W)
    ) u_addr_ptr (
        .clk_8rs (clk_8rs),
        .resetb  (resetb),
        .load    (ptr_load),
        .inc     (ptr_inc),
        .value   (cfg_addr),
        .ptr     (addr_ptr)
    );

    // Strobes decode straight from state so reset drops them asynchronously.
    assign mem_req     = in_req;
    assign mem_we      = (state_q == StWrReq);
    assign mem_bank_en = in_req ? bank_q : '0;
    assign mem_addr    = addr_ptr;
    assign mem_wdata   = wdata_q;
    assign rd_data     = rd_data_q;
    assign rd_done     = rd_done_q;
    assign wr_done     = wr_done_q;
    assign busy        = ~is_idle;
    assign err_overrun = err_overrun_q;
    assign err_nobank  = err_nobank_q;

endmodule

// File: tb/tb_cyborg65r3_sram_access_ctrl.sv
// Self-checking bench for cyborg65r3_sram_access_ctrl.
module tb_cyborg65r3_sram_access_ctrl;

    localparam int NB = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk_8rs = 1'b0;
    logic          resetb;
    logic [NB-1:0] cfg_bank_en;
    logic          cfg_auto_inc;
    logic [AW-1:0] cfg_addr;
    logic          cfg_addr_load;
    logic [DW-1:0] cfg_wdata;
    logic          start_wr, start_rd, err_clr;
    logic          mem_req, mem_we;
    logic [NB-1:0] mem_bank_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rd_data;
    logic          rd_done, wr_done, busy;
    logic [AW-1:0] addr_ptr;
    logic          err_overrun, err_nobank;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [AW-1:0] exp_ptr;
    logic [DW-1:0] exp_rd;
    logic [NB-1:0] exp_bank;
    logic [DW-1:0] exp_wdata;

    cyborg65r3_sram_access_ctrl dut (
        .clk_8rs       (clk_8rs),
        .resetb        (resetb),
        .cfg_bank_en   (cfg_bank_en),
        .cfg_auto_inc  (cfg_auto_inc),
        .cfg_addr      (cfg_addr),
        .cfg_addr_load (cfg_addr_load),
        .cfg_wdata     (cfg_wdata),
        .start_wr      (start_wr),
        .start_rd      (start_rd),
        .err_clr       (err_clr),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_bank_en   (mem_bank_en),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rdata     (mem_rdata),
        .rd_data       (rd_data),
        .rd_done       (rd_done),
        .wr_done       (wr_done),
        .busy          (busy),
        .addr_ptr      (addr_ptr),
        .err_overrun   (err_overrun),
        .err_nobank    (err_nobank)
    );

    always #5 clk_8rs = ~clk_8rs;

    task automatic step;
        @(posedge clk_8rs);
        #1;
    endtask

    // One complete access with a grant after gdelay waiting cycles.
    task automatic run_access(input bit wr, input int gdelay, input logic [DW-1:0] rdval,
                              input bit load_now, input logic [AW-1:0] load_val,
                              input bit noise, input string name);
        if (load_now) begin
            cfg_addr      = load_val;
            cfg_addr_load = 1'b1;
            exp_ptr       = load_val;
        end
        exp_bank  = cfg_bank_en;
        exp_wdata = cfg_wdata;
        start_wr  = wr;
        start_rd  = !wr;
        step;
        start_wr      = 1'b0;
        start_rd      = 1'b0;
        cfg_addr_load = 1'b0;
        if (noise) begin
            cfg_bank_en = NB'($urandom_range(1, 15));
            cfg_wdata   = DW'($urandom);
        end
        for (int c = 0; c <= gdelay; c++) begin
            if (noise) begin
                cfg_addr      = AW'($urandom);
                cfg_addr_load = 1'b1;
            end
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== wr || mem_addr !== exp_ptr ||
                mem_bank_en !== exp_bank || busy !== 1'b1 || wr_done !== 1'b0 ||
                rd_done !== 1'b0 || (wr && mem_wdata !== exp_wdata)) begin
                n_fail++;
                $display("FAIL %s req_cycle%0d: got req=%b we=%b addr=%h bank=%b wdata=%h busy=%b wr_done=%b rd_done=%b, want req=1 we=%b addr=%h bank=%b wdata=%h busy=1 dones=0",
                         name, c, mem_req, mem_we, mem_addr, mem_bank_en, mem_wdata, busy,
                         wr_done, rd_done, wr, exp_ptr, exp_bank, exp_wdata);
            end
            mem_gnt = (c == gdelay);
            step;
        end
        mem_gnt       = 1'b0;
        cfg_addr_load = 1'b0;
        if (!wr) begin
            mem_rdata = rdval;
            n_checks++;
            if (mem_req !== 1'b0 || busy !== 1'b1 || rd_done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s rd_wait: got req=%b busy=%b rd_done=%b, want 0 1 0",
                         name, mem_req, busy, rd_done);
            end
            step;
            mem_rdata = DW'($urandom);
            exp_rd    = rdval;
        end
        n_checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_bank_en !== '0 || busy !== 1'b1 ||
            wr_done !== wr || rd_done !== !wr || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL %s done: got req=%b we=%b bank=%b busy=%b wr_done=%b rd_done=%b rd_data=%h, want 0 0 0 1 %b %b %h",
                     name, mem_req, mem_we, mem_bank_en, busy, wr_done, rd_done, rd_data,
                     wr, !wr, exp_rd);
        end
        if (cfg_auto_inc) exp_ptr = exp_ptr + 1'b1;
        step;
        n_checks++;
        if (busy !== 1'b0 || wr_done !== 1'b0 || rd_done !== 1'b0 || addr_ptr !== exp_ptr ||
            rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL %s idle: got busy=%b wr_done=%b rd_done=%b ptr=%h rd_data=%h, want 0 0 0 %h %h",
                     name, busy, wr_done, rd_done, addr_ptr, rd_data, exp_ptr, exp_rd);
        end
    endtask

    task automatic test_reset;
        resetb        = 1'b0;
        cfg_bank_en   = '0;
        cfg_auto_inc  = 1'b0;
        cfg_addr      = '0;
        cfg_addr_load = 1'b0;
        cfg_wdata     = '0;
        start_wr      = 1'b0;
        start_rd      = 1'b0;
        err_clr       = 1'b0;
        mem_gnt       = 1'b0;
        mem_rdata     = '0;
        exp_ptr       = '0;
        exp_rd        = '0;
        #23;
        n_checks++;
        if ({mem_req, mem_we, mem_bank_en, busy, rd_done, wr_done, err_overrun, err_nobank,
             mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_strobes: got req=%b we=%b bank=%b busy=%b dones=%b%b errs=%b%b wdata=%h, want all 0",
                     mem_req, mem_we, mem_bank_en, busy, rd_done, wr_done, err_overrun,
                     err_nobank, mem_wdata);
        end
        n_checks++;
        if (addr_ptr !== '0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got ptr=%h rd_data=%h, want 0 0", addr_ptr, rd_data);
        end
        step;
        resetb = 1'b1;
        step;
    endtask

    task automatic test_write;
        cfg_auto_inc  = 1'b1;
        cfg_bank_en   = 4'b0010;
        cfg_wdata     = 16'hA5C3;
        cfg_addr      = 12'h010;
        cfg_addr_load = 1'b1;
        step;
        cfg_addr_load = 1'b0;
        exp_ptr       = 12'h010;
        n_checks++;
        if (addr_ptr !== 12'h010) begin
            n_fail++;
            $display("FAIL addr_load: got ptr=%h, want 010", addr_ptr);
        end
        run_access(1'b1, 0, '0, 1'b0, '0, 1'b0, "write_basic");
        n_checks++;
        if (addr_ptr !== 12'h011) begin
            n_fail++;
            $display("FAIL write_autoinc: got ptr=%h, want 011", addr_ptr);
        end
    endtask

    task automatic test_read_delayed;
        cfg_bank_en = 4'b0100;
        run_access(1'b0, 5, 16'h1234, 1'b0, '0, 1'b0, "read_gnt5");
        n_checks++;
        if (rd_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL read_data: got rd_data=%h, want 1234", rd_data);
        end
    endtask

    task automatic test_wrap;
        cfg_auto_inc = 1'b1;
        cfg_bank_en  = 4'b0001;
        cfg_wdata    = 16'h0F0F;
        // Load coinciding with the start: access must use 0xFFF.
        run_access(1'b1, 0, '0, 1'b1, 12'hFFF, 1'b0, "wrap");
        n_checks++;
        if (addr_ptr !== 12'h000) begin
            n_fail++;
            $display("FAIL wrap_ptr: got ptr=%h, want 000", addr_ptr);
        end
    endtask

    task automatic test_overrun;
        int writes = 0;
        int reads  = 0;
        cfg_bank_en = 4'b1010;
        for (int c = 0; c < 7; c++) begin
            start_wr = (c == 0);
            start_rd = (c == 0) || (c == 1);
            mem_gnt  = (c == 2);
            step;
            if (wr_done) writes++;
            if (rd_done || (mem_req && !mem_we)) reads++;
        end
        start_wr = 1'b0;
        start_rd = 1'b0;
        mem_gnt  = 1'b0;
        if (cfg_auto_inc) exp_ptr = exp_ptr + 1'b1;
        n_checks++;
        if (writes != 1 || reads != 0 || err_overrun !== 1'b1 || err_nobank !== 1'b0 ||
            addr_ptr !== exp_ptr) begin
            n_fail++;
            $display("FAIL overrun: got writes=%0d reads=%0d err_overrun=%b err_nobank=%b ptr=%h, want 1 0 1 0 %h",
                     writes, reads, err_overrun, err_nobank, addr_ptr, exp_ptr);
        end
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        n_checks++;
        if (err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got err_overrun=%b, want 0", err_overrun);
        end
        // Clear coinciding with a busy start: the set must win.
        start_wr = 1'b1;
        step;
        start_wr = 1'b0;
        start_rd = 1'b1;
        err_clr  = 1'b1;
        step;
        start_rd = 1'b0;
        err_clr  = 1'b0;
        n_checks++;
        if (err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_set: got err_overrun=%b, want 1", err_overrun);
        end
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        step;
        if (cfg_auto_inc) exp_ptr = exp_ptr + 1'b1;
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        n_checks++;
        if (err_overrun !== 1'b0 || busy !== 1'b0 || addr_ptr !== exp_ptr) begin
            n_fail++;
            $display("FAIL overrun_final: got err_overrun=%b busy=%b ptr=%h, want 0 0 %h",
                     err_overrun, busy, addr_ptr, exp_ptr);
        end
    endtask

    task automatic test_nobank_reset;
        int bad = 0;
        cfg_bank_en = '0;
        start_rd    = 1'b1;
        step;
        start_rd = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (mem_req || busy || rd_done) bad++;
            step;
        end
        n_checks++;
        if (bad != 0 || err_nobank !== 1'b1 || err_overrun !== 1'b0 || addr_ptr !== exp_ptr) begin
            n_fail++;
            $display("FAIL nobank: got bad_cycles=%0d err_nobank=%b err_overrun=%b ptr=%h, want 0 1 0 %h",
                     bad, err_nobank, err_overrun, addr_ptr, exp_ptr);
        end
        cfg_bank_en = 4'b1000;
        start_rd    = 1'b1;
        step;
        start_rd = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_req_before_reset: got req=%b, want 1", mem_req);
        end
        #2;
        resetb = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_bank_en, busy, rd_done, wr_done, err_overrun, err_nobank} !== '0 ||
            addr_ptr !== '0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b we=%b bank=%b busy=%b dones=%b%b errs=%b%b ptr=%h rd_data=%h, want all 0",
                     mem_req, mem_we, mem_bank_en, busy, rd_done, wr_done, err_overrun,
                     err_nobank, addr_ptr, rd_data);
        end
        exp_ptr = '0;
        exp_rd  = '0;
        mem_gnt = 1'b1;
        step;
        resetb = 1'b1;
        bad    = 0;
        mem_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step;
            if (rd_done || busy || mem_req) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %0d active cycles, want 0", bad);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            bit            wr;
            int            gd;
            bit            ld;
            logic [AW-1:0] lv;
            logic [DW-1:0] rv;
            bit            nz;
            wr           = 1'($urandom_range(0, 1));
            gd           = $urandom_range(0, 4);
            ld           = ($urandom_range(0, 3) == 0);
            lv           = AW'($urandom);
            rv           = DW'($urandom);
            nz           = 1'($urandom_range(0, 1));
            cfg_auto_inc = 1'($urandom_range(0, 1));
            cfg_bank_en  = NB'($urandom_range(1, 15));
            cfg_wdata    = DW'($urandom);
            run_access(wr, gd, rv, ld, lv, nz, "random");
            for (int g = $urandom_range(0, 2); g > 0; g--) step;
        end
        n_checks++;
        if (err_overrun !== 1'b0 || err_nobank !== 1'b0) begin
            n_fail++;
            $display("FAIL random_errs: got err_overrun=%b err_nobank=%b, want 0 0",
                     err_overrun, err_nobank);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_delayed;
        test_wrap;
        test_overrun;
        test_nobank_reset;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cyborg65r3_sram_access_ctrl.md
CYBORG65R3_SRAM_ACCESS_CTRL -- requirements
Module: cyborg65r3_sram_access_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_BANKS, default 4, number of SRAM coefficient banks; ADDR_W, default 12, word-address width; DATA_W, default 16, data width.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with ports exactly as follows.
REQ-003 clk_8rs  in  1  the only clock; all state updates on its rising edge.
REQ-004 resetb  in  1  asynchronous, active-low reset.
REQ-005 cfg_bank_en  in  NUM_BANKS  per-bank enable, from config registers.
REQ-006 cfg_auto_inc  in  1  advance the address pointer after each access.
REQ-007 cfg_addr  in  ADDR_W  start address from config registers.
REQ-008 cfg_addr_load  in  1  one-cycle pulse; loads cfg_addr into the pointer.
REQ-009 cfg_wdata  in  DATA_W  write data from config registers.
REQ-010 start_wr, start_rd  in  1 each  one-cycle request pulses.
REQ-011 err_clr  in  1  clears the sticky error flags.
REQ-012 mem_req  out  1  memory request; held until granted.
REQ-013 mem_we  out  1  memory write strobe qualifier.
REQ-014 mem_bank_en  out  NUM_BANKS  bank selects.
REQ-015 mem_addr  out  ADDR_W  memory address.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_gnt  in  1  grant from the DSP/config arbiter.
REQ-018 mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after the granted read.
REQ-019 rd_data  out  DATA_W  captured read word.
REQ-020 rd_done, wr_done  out  1 each  one-cycle completion pulses.
REQ-021 busy  out  1  high whenever the FSM is not in IDLE.
REQ-022 addr_ptr  out  ADDR_W  current pointer value.
REQ-023 err_overrun, err_nobank  out  1 each  sticky error flags.

Function
REQ-024 The FSM SHALL have exactly the states IDLE, WR_REQ, RD_REQ, RD_WAIT and DONE.
REQ-025 IDLE SHALL transition as follows: start_wr -> WR_REQ; start_rd -> RD_REQ; if both are asserted in the same cycle, the write wins, the read is dropped and err_overrun is set.
REQ-026 A start SHALL be rejected whenever cfg_bank_en==0: the FSM stays in IDLE, err_nobank is set and no done pulse is issued.
REQ-027 On acceptance, the block SHALL latch cfg_bank_en and cfg_wdata, and the pointer SHALL drive mem_addr for the whole access.
REQ-028 WR_REQ SHALL drive mem_req=1 and mem_we=1 until mem_gnt; in the grant cycle it SHALL move to DONE.
REQ-029 In the cycle after DONE is entered from WR_REQ, wr_done SHALL be 1 for exactly 1 cycle; write latency is start -> wr_done = 2 cycles with immediate grant.
REQ-030 RD_REQ SHALL drive mem_req=1 and mem_we=0 until mem_gnt, then move to RD_WAIT.
REQ-031 RD_WAIT SHALL capture mem_rdata into rd_data and move to DONE; rd_done SHALL be 1 for 1 cycle with rd_data already valid; read latency with immediate grant = 3 cycles.
REQ-032 DONE SHALL return to IDLE in 1 cycle.
REQ-033 mem_req, mem_we and mem_bank_en SHALL be 0 outside WR_REQ and RD_REQ.
REQ-034 A start_wr or start_rd arriving while busy=1 SHALL be ignored and SHALL set err_overrun.
REQ-035 Errors SHALL be sticky until err_clr; if err_clr coincides with a new error event, the set wins.
REQ-036 After a completed access with cfg_auto_inc=1, the pointer SHALL increment modulo 2^ADDR_W (all-ones wraps to 0); with cfg_auto_inc=0 it SHALL hold.
REQ-037 cfg_addr_load SHALL load the pointer only in IDLE; while busy it SHALL be ignored without setting an error.
REQ-038 If cfg_addr_load and an accepted start occur in the same cycle, the access SHALL use the newly loaded cfg_addr.
REQ-039 rd_data SHALL hold its value until the next completed read.

Reset
REQ-040 While resetb=0, the FSM SHALL be in IDLE, and addr_ptr, rd_data, all strobes, busy and both error flags SHALL be 0.
REQ-041 Reset asserted mid-access SHALL abort the access immediately, with no done pulse; mem_req SHALL drop asynchronously.

Structure
REQ-042 The state enum and the default parameter values SHALL live in the shared package cyborg65r3_pkg.
REQ-043 The address pointer/incrementer SHALL be one sub-module, cyborg65r3_addr_ptr, with inputs load, inc and value and output ptr.

Verification
REQ-044 Scenario: cfg_addr=0x010 load, cfg_bank_en=4'b0010, cfg_wdata=0xA5C3, start_wr, mem_gnt tied 1 -> mem_addr=0x010, mem_we=1, mem_bank_en=0010, wr_done 2 cycles after start; with auto_inc=1, addr_ptr=0x011.
REQ-045 Scenario: start_rd with mem_gnt delayed 5 cycles and mem_rdata=0x1234 the cycle after the grant -> mem_req held 6 cycles, rd_done 2 cycles after the grant, rd_data=0x1234.
REQ-046 Scenario: addr_ptr=0xFFF, auto_inc=1, one write -> addr_ptr=0x000.
REQ-047 Scenario: start_wr and start_rd in the same cycle, then start_rd while busy -> exactly one write occurs and err_overrun=1; err_clr -> 0.
REQ-048 Scenario: cfg_bank_en=0 with start_rd -> no mem_req, err_nobank=1; resetb pulsed during RD_REQ -> all outputs 0 and no rd_done.
